picoblaze_irq_ctrl: RTL and testbench
=====================================

// Module: picoblaze_irq_ctrl
// PURPOSE
//   Interrupt controller for the KCPSM6 (PicoBlaze) processor. Collects up to 8 peripheral
//   interrupt requests, arbitrates them and drives the processor interrupt/interrupt_ack
//   handshake. Software reads/writes mask, pending, active and EOI registers through the
//   processor's port_id/out_port/in_port bus. Sits beside kcpsm6 in the processor top and
//   replaces the tied-off interrupt input.
// PARAMETERS
//   N_SRC      4      number of request sources, legal range 1..8
//   BASE_PORT  8'h10  port address of register 0; must be a multiple of 4
// PORTS
//   clk            in   1      system clock, all logic on rising edge
//   reset          in   1      asynchronous, active-high reset
//   irq_req        in   N_SRC  source requests, synchronous to clk, rising-edge sensitive
//   port_id        in   8      kcpsm6 port address
//   out_port       in   8      kcpsm6 write data
//   write_strobe   in   1      kcpsm6 OUTPUT strobe
//   k_write_strobe in   1      kcpsm6 OUTPUTK strobe, qualifies writes same as write_strobe
//   read_strobe    in   1      kcpsm6 INPUT strobe
//   rd_data        out  8      registered read data, ORed into top-level in_port mux
//   interrupt      out  1      to kcpsm6 interrupt
//   interrupt_ack  in   1      from kcpsm6 interrupt_ack
// BEHAVIOUR
//   Register select: hit = (port_id[7:2] == BASE_PORT[7:2]); offset = port_id[1:0].
//     0 MASK   RW  bit i = 1 enables source i; reset 8'h00 (all disabled)
//     1 PEND   R: pending bits; W: write-1-to-clear
//     2 ACTIVE R: {in_service, 4'b0, active_id[2:0]}; writes ignored
//     3 EOI    W: any data ends service; reads return 8'h00
//   Bits >= N_SRC in MASK/PEND read 0, writes ignored.
//   rd_data: registered each clk; register value on hit, else 8'h00 (1-cycle latency,
//     valid before kcpsm6 samples in_port). read_strobe has no side effects.
//   Edge detect: irq_d registered; pend[i] set when irq_req[i] & ~irq_d[i]. Set is not
//     counted; a second edge while pending is lost.
//   Same-cycle set and W1C on the same bit: set wins.
//   eligible = pend & mask. Selection is fixed priority, lowest index highest.
//   FSM (reset -> IDLE):
//     IDLE    : interrupt=0; if eligible!=0 and !in_service, latch sel -> ASSERT.
//     ASSERT  : interrupt=1; on interrupt_ack: pend[sel] cleared, active_id<=sel,
//               in_service<=1 -> SERVICE. If eligible[sel] drops before ack (masked or
//               W1C), interrupt deasserts next cycle -> IDLE.
//     SERVICE : interrupt=0; new edges accumulate in PEND; EOI write -> in_service<=0,
//               -> IDLE. Next request can assert no earlier than 1 cycle after EOI.
//   interrupt_ack in IDLE or SERVICE is ignored. No nesting.
//   Reset values: interrupt=0, rd_data=0, MASK=0, PEND=0, irq_d=0, in_service=0,
//     active_id=0, state=IDLE. Reset mid-handshake returns to IDLE immediately.
//     Requests high at reset release do not register as edges until they go low then high.
// CONFIGURATION
//   ROUND_ROBIN_EN defined: rotating priority. Search starts at (last_acked_id+1) mod N_SRC;
//     last_acked_id resets to N_SRC-1, so the first search starts at source 0.
//   Not defined: fixed priority as above; no last_acked_id register.
// TESTING
//   1 MASK=8'h0F, pulse irq_req[2] -> PEND=8'h04, interrupt=1 within 2 cycles;
//     ack -> PEND=0, ACTIVE=8'h82, interrupt=0.
//   2 MASK=0, pulse irq_req[1] -> PEND=8'h02, interrupt stays 0; write MASK=8'h02 -> interrupt=1.
//   3 Edges on sources 3 and 1 in the same cycle -> ACTIVE=8'h81 after ack; EOI, then source 3
//     is serviced (ACTIVE=8'h83). With ROUND_ROBIN_EN after servicing 1 with 1 and 3 both
//     pending again -> 3 is selected first.
//   4 In ASSERT, write PEND=8'h04 (W1C of sel=2) -> interrupt=0 next cycle, FSM IDLE,
//     no ack needed.
//   5 Edge on irq_req[0] in the same cycle as W1C 8'h01 -> PEND bit 0 remains 1.
//   6 Assert reset while interrupt=1 and in SERVICE -> all outputs 0 asynchronously;
//     after release, a held-high irq_req produces no PEND bit.

Source files
------------

// File: rtl/picoblaze_irq_ctrl.sv
// ---------------------------------------------------------------------------
// picoblaze_irq_ctrl
//   Interrupt controller placed beside a KCPSM6 (PicoBlaze) core. Captures
//   rising edges on up to 8 request lines into a pending register, qualifies
//   them with a software mask, picks one source and runs the processor's
//   interrupt / interrupt_ack handshake. Software sees four byte registers at
//   BASE_PORT..BASE_PORT+3 on the port_id/out_port/in_port bus:
//     +0 MASK   RW  source enables
//     +1 PEND   R pending bits, W write-1-to-clear
//     +2 ACTIVE R {in_service, 4'b0, active_id}
//     +3 EOI    W any value ends the current service, reads 0
//
//   Optional build macro: ROUND_ROBIN_EN
//     defined   -> rotating priority starting after the last acknowledged id
//     undefined -> fixed priority, lowest index wins
//
// Ports
//   clk             system clock (rising edge)
//   reset           asynchronous active-high reset
//   irq_req         source requests, rising-edge sensitive
//   port_id         processor port address
//   out_port        processor write data
//   write_strobe    OUTPUT strobe
//   k_write_strobe  OUTPUTK strobe (treated like write_strobe)
//   read_strobe     INPUT strobe (reads have no side effects)
//   rd_data         registered read data, ORed into the in_port mux
//   interrupt       interrupt request to the processor
//   interrupt_ack   acknowledge from the processor
// ---------------------------------------------------------------------------
module picoblaze_irq_ctrl #(
  parameter int          N_SRC     = 4,
  parameter logic [7:0]  BASE_PORT = 8'h10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_req,
  input  logic [7:0]       port_id,
  input  logic [7:0]       out_port,
  input  logic             write_strobe,
  input  logic             k_write_strobe,
  input  logic             read_strobe,
  output logic [7:0]       rd_data,
  output logic             interrupt,
  input  logic             interrupt_ack
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [N_SRC-1:0]   r_mask;
  logic [N_SRC-1:0]   r_pend;
  logic [N_SRC-1:0]   r_irq_d;
  logic               r_armed;
  logic               r_in_service;
  logic [2:0]         r_active_id;
  logic [2:0]         r_sel;
  logic [7:0]         r_rd_data;

  logic               w_hit;
  logic               w_wr;
  logic               w_wr_mask;
  logic               w_wr_pend;
  logic               w_wr_eoi;
  logic [7:0]         w_mask8;
  logic [7:0]         w_pend8;
  logic [7:0]         w_elig8;
  logic [N_SRC-1:0]   w_edge;
  logic [N_SRC-1:0]   w_w1c;
  logic [N_SRC-1:0]   w_ack_clr;
  logic [2:0]         w_pick;
  logic               w_pick_vld;
  logic               w_take_sel;
  logic               w_ack_take;
  logic [7:0]         w_rd_value;
  logic               w_unused;

  // Reads are side-effect free and write data above N_SRC is don't-care.
  assign w_unused = ^{read_strobe, out_port};

  // ------------------------------------------------------------------
  // Register decode
  // ------------------------------------------------------------------
  assign w_hit     = (port_id[7:2] == BASE_PORT[7:2]);
  assign w_wr      = w_hit && (write_strobe || k_write_strobe);
  assign w_wr_mask = w_wr && (port_id[1:0] == 2'd0);
  assign w_wr_pend = w_wr && (port_id[1:0] == 2'd1);
  assign w_wr_eoi  = w_wr && (port_id[1:0] == 2'd3);

  // Widen MASK/PEND to a byte; unimplemented sources read as 0.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_widen
      if (gi < N_SRC) begin : g_real
        assign w_mask8[gi] = r_mask[gi];
        assign w_pend8[gi] = r_pend[gi];
      end else begin : g_pad
        assign w_mask8[gi] = 1'b0;
        assign w_pend8[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < N_SRC; gi++) begin : g_clr
      assign w_ack_clr[gi] = w_ack_take && (r_sel == 3'(gi));
    end
  endgenerate

  assign w_elig8 = w_pend8 & w_mask8;

  // r_armed stays low for the first clock after reset so that a line which
  // was already high at release is loaded into r_irq_d without being seen as
  // an edge; it must drop and rise again to register.
  assign w_edge = irq_req & ~r_irq_d & {N_SRC{r_armed}};
  assign w_w1c  = w_wr_pend ? out_port[N_SRC-1:0] : '0;

  // ------------------------------------------------------------------
  // Source selection
  // ------------------------------------------------------------------
`ifdef ROUND_ROBIN_EN
  logic [2:0] r_last_acked;
  logic [2:0] w_rr_start;
  logic [3:0] w_rr_idx;

  always_comb begin
    w_pick     = 3'd0;
    w_pick_vld = 1'b0;
    w_rr_idx   = 4'd0;
    w_rr_start = (r_last_acked == 3'(N_SRC-1)) ? 3'd0 : r_last_acked + 3'd1;
    for (int k = 0; k < N_SRC; k++) begin
      w_rr_idx = {1'b0, w_rr_start} + 4'(k);
      if (w_rr_idx >= 4'(N_SRC)) begin
        w_rr_idx = w_rr_idx - 4'(N_SRC);
      end
      if (!w_pick_vld && w_elig8[w_rr_idx[2:0]]) begin
        w_pick     = w_rr_idx[2:0];
        w_pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_acked <= 3'(N_SRC-1);
    end else if (w_ack_take) begin
      r_last_acked <= r_sel;
    end
  end
`else
  // Scan downwards so the lowest eligible index is the one left standing.
  always_comb begin
    w_pick     = 3'd0;
    w_pick_vld = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_elig8[k]) begin
        w_pick     = 3'(k);
        w_pick_vld = 1'b1;
      end
    end
  end
`endif

  // ------------------------------------------------------------------
  // Handshake FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld && !r_in_service) begin
          w_state_next = S_ASSERT;
        end
      end
      S_ASSERT: begin
        // A source withdrawn by mask or W1C cancels the request.
        if (!w_elig8[r_sel]) begin
          w_state_next = S_IDLE;
        end else if (interrupt_ack) begin
          w_state_next = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (w_wr_eoi) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    interrupt = (r_state == S_ASSERT);
  end

  assign w_take_sel = (r_state == S_IDLE) && (w_state_next == S_ASSERT);
  assign w_ack_take = (r_state == S_ASSERT) && (w_state_next == S_SERVICE);

  // ------------------------------------------------------------------
  // Register file and status
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask       <= '0;
      r_pend       <= '0;
      r_irq_d      <= '0;
      r_armed      <= 1'b0;
      r_in_service <= 1'b0;
      r_active_id  <= 3'd0;
      r_sel        <= 3'd0;
    end else begin
      r_irq_d <= irq_req;
      r_armed <= 1'b1;
      if (w_wr_mask) begin
        r_mask <= out_port[N_SRC-1:0];
      end
      // New edges override a same-cycle clear.
      r_pend <= (r_pend & ~w_w1c & ~w_ack_clr) | w_edge;
      if (w_take_sel) begin
        r_sel <= w_pick;
      end
      if (w_ack_take) begin
        r_active_id  <= r_sel;
        r_in_service <= 1'b1;
      end else if (w_wr_eoi) begin
        r_in_service <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd_value = 8'h00;
    case (port_id[1:0])
      2'd0:    w_rd_value = w_mask8;
      2'd1:    w_rd_value = w_pend8;
      2'd2:    w_rd_value = {r_in_service, 4'b0000, r_active_id};
      default: w_rd_value = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= w_hit ? w_rd_value : 8'h00;
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_picoblaze_irq_ctrl.sv
module tb_picoblaze_irq_ctrl;

  localparam logic [7:0] A_MASK   = 8'h10;
  localparam logic [7:0] A_PEND   = 8'h11;
  localparam logic [7:0] A_ACTIVE = 8'h12;
  localparam logic [7:0] A_EOI    = 8'h13;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_req = 4'h0;
  logic [7:0] port_id = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic       write_strobe = 1'b0;
  logic       k_write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] rd_data;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  picoblaze_irq_ctrl #(.N_SRC(4), .BASE_PORT(8'h10)) dut (
    .clk            (clk),
    .reset          (reset),
    .irq_req        (irq_req),
    .port_id        (port_id),
    .out_port       (out_port),
    .write_strobe   (write_strobe),
    .k_write_strobe (k_write_strobe),
    .read_strobe    (read_strobe),
    .rd_data        (rd_data),
    .interrupt      (interrupt),
    .interrupt_ack  (interrupt_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a; out_port = d; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0; port_id = 8'h00;
    $display("write port=%02h data=%02h", a, d);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    port_id = a; read_strobe = 1'b1;
    tick();
    d = rd_data;
    read_strobe = 1'b0; port_id = 8'h00;
    $display("read  port=%02h data=%02h", a, d);
  endtask

  task automatic pulse(input logic [3:0] b);
    irq_req = irq_req | b;
    tick();
    irq_req = irq_req & ~b;
    $display("pulse irq=%h", b);
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    $display("ack");
  endtask

  task automatic test_reset();
    logic [7:0] d;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_int got=%b exp=0", interrupt); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd got=%02h exp=00", rd_data); end
    rd(A_MASK, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mask got=%02h exp=00", d); end
    rd(A_PEND, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_pend got=%02h exp=00", d); end
    rd(A_ACTIVE, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_active got=%02h exp=00", d); end
    wr(A_MASK, 8'hFF);
    rd(A_MASK, d);
    checks++; if (d !== 8'h0F) begin errors++; $display("FAIL mask_width got=%02h exp=0F", d); end
    rd(A_EOI, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL eoi_read got=%02h exp=00", d); end
    wr(A_MASK, 8'h00);
  endtask

  task automatic test_basic();
    logic [7:0] d;
    wr(A_MASK, 8'h0F);
    pulse(4'h4);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL basic_int_early got=%b exp=0", interrupt); end
    rd(A_PEND, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL basic_pend got=%02h exp=04", d); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL basic_int got=%b exp=1", interrupt); end
    ack();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL basic_int_after_ack got=%b exp=0", interrupt); end
    rd(A_PEND, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL basic_pend_cleared got=%02h exp=00", d); end
    rd(A_ACTIVE, d);
    checks++; if (d !== 8'h82) begin errors++; $display("FAIL basic_active got=%02h exp=82", d); end
    wr(A_EOI, 8'h00);
    rd(A_ACTIVE, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL basic_active_eoi got=%02h exp=02", d); end
  endtask

  task automatic test_mask();
    logic [7:0] d;
    wr(A_MASK, 8'h00);
    pulse(4'h2);
    tick(); tick();
    rd(A_PEND, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL mask_pend got=%02h exp=02", d); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_int_off got=%b exp=0", interrupt); end
    wr(A_MASK, 8'h02);
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL mask_int_on got=%b exp=1", interrupt); end
    ack();
    wr(A_EOI, 8'h5A);
  endtask

  task automatic test_priority();
    logic [7:0] d;
    wr(A_MASK, 8'h0F);
    pulse(4'hA);
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL prio_int got=%b exp=1", interrupt); end
    ack();
    rd(A_ACTIVE, d);
    checks++; if (d !== 8'h81) begin errors++; $display("FAIL prio_active1 got=%02h exp=81", d); end
    rd(A_PEND, d);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL prio_pend got=%02h exp=08", d); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL prio_int_in_service got=%b exp=0", interrupt); end
    wr(A_EOI, 8'h00);
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL prio_int2 got=%b exp=1", interrupt); end
    ack();
    rd(A_ACTIVE, d);
    checks++; if (d !== 8'h83) begin errors++; $display("FAIL prio_active3 got=%02h exp=83", d); end
    wr(A_EOI, 8'h00);
  endtask

  task automatic test_rotation();
    logic [7:0] d;
    logic [7:0] exp_first;
`ifdef ROUND_ROBIN_EN
    exp_first = 8'h83;
`else
    exp_first = 8'h81;
`endif
    pulse(4'h2);
    tick();
    ack();
    pulse(4'hA);
    tick();
    wr(A_EOI, 8'h00);
    tick();
    ack();
    rd(A_ACTIVE, d);
    checks++; if (d !== exp_first) begin errors++; $display("FAIL rot_first got=%02h exp=%02h", d, exp_first); end
    wr(A_EOI, 8'h00);
    tick();
    ack();
    wr(A_EOI, 8'h00);
    rd(A_PEND, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rot_pend_empty got=%02h exp=00", d); end
  endtask

  task automatic test_cancel();
    logic [7:0] d;
    pulse(4'h4);
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL cancel_int_on got=%b exp=1", interrupt); end
    wr(A_PEND, 8'h04);
    tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL cancel_int_off got=%b exp=0", interrupt); end
    ack();
    rd(A_ACTIVE, d);
    checks++; if ((d & 8'h80) !== 8'h00) begin errors++; $display("FAIL cancel_in_service got=%02h exp=0x", d); end
    rd(A_PEND, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL cancel_pend got=%02h exp=00", d); end
  endtask

  task automatic test_set_wins();
    logic [7:0] d;
    wr(A_MASK, 8'h00);
    irq_req = 4'h1;
    port_id = A_PEND; out_port = 8'h01; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0; port_id = 8'h00; irq_req = 4'h0;
    $display("w1c pend=01 with edge on src0");
    rd(A_PEND, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL set_wins got=%02h exp=01", d); end
    port_id = A_PEND; out_port = 8'h01; k_write_strobe = 1'b1;
    tick();
    k_write_strobe = 1'b0; port_id = 8'h00;
    $display("outputk pend=01");
    rd(A_PEND, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL kwrite_w1c got=%02h exp=00", d); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    wr(A_MASK, 8'h0F);
    pulse(4'h4);
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL ar_int_pre got=%b exp=1", interrupt); end
    #3 reset = 1'b1;
    #1;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ar_int_assert got=%b exp=0", interrupt); end
    tick();
    reset = 1'b0;
    wr(A_MASK, 8'h0F);
    pulse(4'h4);
    tick();
    ack();
    port_id = A_ACTIVE; read_strobe = 1'b1;
    tick();
    checks++; if (rd_data !== 8'h82) begin errors++; $display("FAIL ar_rd_pre got=%02h exp=82", rd_data); end
    #3 reset = 1'b1;
    irq_req = 4'h8;
    #1;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL ar_rd_async got=%02h exp=00", rd_data); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ar_int_service got=%b exp=0", interrupt); end
    read_strobe = 1'b0; port_id = 8'h00;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    wr(A_MASK, 8'h0F);
    rd(A_PEND, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ar_held_high got=%02h exp=00", d); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ar_held_int got=%b exp=0", interrupt); end
    irq_req = 4'h0;
    tick();
    pulse(4'h8);
    rd(A_PEND, d);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL ar_reedge got=%02h exp=08", d); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL ar_reedge_int got=%b exp=1", interrupt); end
  endtask

  initial begin
    #2;
    tick(); tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_mask();
    test_priority();
    test_rotation();
    test_cancel();
    test_set_wins();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
